// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state and parity-mode encodings for the UART RX frame checker
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    DONE
  } rx_state_t;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  // Expected parity bit given the mode and the XOR-reduction of the data word.
  function automatic logic expected_parity(input logic [1:0] mode, input logic data_xor);
    logic exp_bit;
    case (mode)
      PAR_EVEN: exp_bit = data_xor;
      PAR_ODD:  exp_bit = ~data_xor;
      PAR_MARK: exp_bit = 1'b1;
      default:  exp_bit = 1'b0;
    endcase
    return exp_bit;
  endfunction

endpackage

// File: rtl/uart_rx_err_counter.sv
// rtl/uart_rx_err_counter.sv - saturating error counter, clear has priority over increment
module uart_rx_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_frame_check.sv
// rtl/uart_rx_frame_check.sv - UART RX frame assembly with parity and stop-bit checking
// Optional error counters are built when UART_RX_ERR_CNT_EN is defined.
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              bit_valid,
  input  logic              sampled_bit,
  input  logic              par_en,
  input  logic [1:0]        par_mode,
  input  logic              stop2,
  input  logic              err_clr,
  output logic [DATA_W-1:0] p_data,
  output logic              frame_valid,
  output logic              par_error,
  output logic              stop_error,
  output logic              busy
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  par_err_cnt,
  output logic [CNT_W-1:0]  stop_err_cnt
`endif
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);

  rx_state_t         state, state_next;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] shift_q;
  logic              par_en_q, stop2_q;
  logic [1:0]        par_mode_q;
  logic              par_flag, stop_flag;
  logic              data_last, stop_last;

  assign data_last   = bit_valid && (bit_cnt == LAST_DATA);
  assign stop_last   = bit_valid && (stop2_q ? (bit_cnt == 4'd1) : 1'b1);
  assign frame_valid = (state == DONE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = DATA;
      DATA:    if (data_last) state_next = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_valid) state_next = STOP;
      STOP:    if (stop_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Results are loaded on the edge that consumes the final stop bit so they
  // are already valid during the single DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      par_mode_q <= PAR_EVEN;
      par_flag   <= 1'b0;
      stop_flag  <= 1'b0;
      p_data     <= '0;
      par_error  <= 1'b0;
      stop_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            bit_cnt    <= '0;
            par_en_q   <= par_en;
            stop2_q    <= stop2;
            par_mode_q <= par_mode;
            par_flag   <= 1'b0;
            stop_flag  <= 1'b0;
          end
        end
        DATA: begin
          if (bit_valid) begin
            shift_q <= {sampled_bit, shift_q[DATA_W-1:1]};
            bit_cnt <= data_last ? 4'd0 : bit_cnt + 4'd1;
          end
        end
        PARITY: begin
          if (bit_valid) begin
            par_flag <= (sampled_bit != expected_parity(par_mode_q, ^shift_q));
          end
        end
        STOP: begin
          if (bit_valid) begin
            bit_cnt   <= bit_cnt + 4'd1;
            stop_flag <= stop_flag | ~sampled_bit;
            if (stop_last) begin
              p_data     <= shift_q;
              par_error  <= par_flag;
              stop_error <= stop_flag | ~sampled_bit;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  uart_rx_err_counter #(.CNT_W(CNT_W)) u_par_cnt (
    .clk (clk),
    .rst (rst),
    .inc (frame_valid & par_error),
    .clr (err_clr),
    .cnt (par_err_cnt)
  );

  uart_rx_err_counter #(.CNT_W(CNT_W)) u_stop_cnt (
    .clk (clk),
    .rst (rst),
    .inc (frame_valid & stop_error),
    .clr (err_clr),
    .cnt (stop_err_cnt)
  );
`else
  logic [CNT_W-1:0] unused_cnt_cfg;
  assign unused_cnt_cfg = {CNT_W{err_clr}};
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// tb/tb_uart_rx_frame_check.sv - directed self-checking bench for uart_rx_frame_check
module tb_uart_rx_frame_check;
  import uart_rx_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, frame_start, bit_valid, sampled_bit, par_en, stop2, err_clr;
  logic [1:0] par_mode;
  logic       frame_start7, bit_valid7;

  logic [7:0] p_data;
  logic       frame_valid, par_error, stop_error, busy;
  logic [6:0] p_data7;
  logic       frame_valid7, par_error7, stop_error7, busy7;
`ifdef UART_RX_ERR_CNT_EN
  logic [1:0] par_err_cnt, stop_err_cnt;
  logic [7:0] par_err_cnt7, stop_err_cnt7;
`endif

  int total = 0;
  int bad   = 0;

  uart_rx_frame_check #(.DATA_W(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid),
    .sampled_bit(sampled_bit), .par_en(par_en), .par_mode(par_mode), .stop2(stop2),
    .err_clr(err_clr), .p_data(p_data), .frame_valid(frame_valid),
    .par_error(par_error), .stop_error(stop_error), .busy(busy)
`ifdef UART_RX_ERR_CNT_EN
    , .par_err_cnt(par_err_cnt), .stop_err_cnt(stop_err_cnt)
`endif
  );

  uart_rx_frame_check #(.DATA_W(7), .CNT_W(8)) dut7 (
    .clk(clk), .rst(rst), .frame_start(frame_start7), .bit_valid(bit_valid7),
    .sampled_bit(sampled_bit), .par_en(par_en), .par_mode(par_mode), .stop2(stop2),
    .err_clr(err_clr), .p_data(p_data7), .frame_valid(frame_valid7),
    .par_error(par_error7), .stop_error(stop_error7), .busy(busy7)
`ifdef UART_RX_ERR_CNT_EN
    , .par_err_cnt(par_err_cnt7), .stop_err_cnt(stop_err_cnt7)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic strobe8(input logic b);
    sampled_bit = b;
    bit_valid   = 1'b1;
    @(negedge clk);
    bit_valid   = 1'b0;
  endtask

  task automatic strobe7(input logic b);
    sampled_bit = b;
    bit_valid7  = 1'b1;
    @(negedge clk);
    bit_valid7  = 1'b0;
  endtask

  // Config inputs are flipped right after the start so latching is exercised on every frame.
  task automatic start8(input logic pe, input logic [1:0] mode, input logic s2);
    par_en      = pe;
    par_mode    = mode;
    stop2       = s2;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    par_en      = ~pe;
    par_mode    = ~mode;
    stop2       = ~s2;
  endtask

  task automatic frame8(input logic [7:0] d, input logic pe, input logic [1:0] mode,
                        input logic pb, input logic s2, input logic sb1, input logic sb2);
    start8(pe, mode, s2);
    for (int i = 0; i < 8; i++) strobe8(d[i]);
    if (pe) strobe8(pb);
    strobe8(sb1);
    if (s2) strobe8(sb2);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++;
    if ({p_data, frame_valid, par_error, stop_error, busy} !== 12'h000) begin
      bad++;
      $display("FAIL reset_dut8: got %h want %h", {p_data, frame_valid, par_error, stop_error, busy}, 12'h000);
    end
    total++;
    if ({p_data7, frame_valid7, par_error7, stop_error7, busy7} !== 11'h000) begin
      bad++;
      $display("FAIL reset_dut7: got %h want %h", {p_data7, frame_valid7, par_error7, stop_error7, busy7}, 11'h000);
    end
`ifdef UART_RX_ERR_CNT_EN
    total++;
    if ({par_err_cnt, stop_err_cnt, par_err_cnt7, stop_err_cnt7} !== 20'h0) begin
      bad++;
      $display("FAIL reset_cnt: got %h want %h", {par_err_cnt, stop_err_cnt, par_err_cnt7, stop_err_cnt7}, 20'h0);
    end
`endif
  endtask

  task automatic test_even_clean;
    frame8(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if ({p_data, frame_valid, par_error, stop_error, busy} !== {8'hA5, 4'b1001}) begin
      bad++;
      $display("FAIL even_a5_done: got %h want %h", {p_data, frame_valid, par_error, stop_error, busy}, {8'hA5, 4'b1001});
    end
    @(negedge clk);
    total++;
    if ({frame_valid, busy, p_data} !== {2'b00, 8'hA5}) begin
      bad++;
      $display("FAIL even_a5_after: got %h want %h", {frame_valid, busy, p_data}, {2'b00, 8'hA5});
    end
  endtask

  task automatic test_parity_error;
    frame8(8'hA5, 1'b1, PAR_EVEN, 1'b1, 1'b0, 1'b1, 1'b0);
    total++;
    if ({p_data, frame_valid, par_error, stop_error} !== {8'hA5, 3'b110}) begin
      bad++;
      $display("FAIL par_err_a5: got %h want %h", {p_data, frame_valid, par_error, stop_error}, {8'hA5, 3'b110});
    end
    @(negedge clk);
`ifdef UART_RX_ERR_CNT_EN
    total++;
    if (par_err_cnt !== 2'd1) begin
      bad++;
      $display("FAIL par_cnt_first: got %0d want %0d", par_err_cnt, 1);
    end
`endif
    frame8(8'h3C, 1'b1, PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if ({p_data, frame_valid, par_error, stop_error} !== {8'h3C, 3'b100}) begin
      bad++;
      $display("FAIL clean_3c: got %h want %h", {p_data, frame_valid, par_error, stop_error}, {8'h3C, 3'b100});
    end
    @(negedge clk);
`ifdef UART_RX_ERR_CNT_EN
    total++;
    if (par_err_cnt !== 2'd1) begin
      bad++;
      $display("FAIL par_cnt_hold: got %0d want %0d", par_err_cnt, 1);
    end
`endif
  endtask

  task automatic test_modes;
    logic [1:0] modes [3] = '{PAR_ODD, PAR_MARK, PAR_SPACE};
    logic       good  [3] = '{1'b1, 1'b1, 1'b0};
    for (int m = 0; m < 3; m++) begin
      for (int inv = 0; inv < 2; inv++) begin
        frame8(8'h00, 1'b1, modes[m], good[m] ^ inv[0], 1'b0, 1'b1, 1'b0);
        total++;
        if ({frame_valid, par_error, stop_error} !== {1'b1, inv[0], 1'b0}) begin
          bad++;
          $display("FAIL mode%0d_inv%0d: got %b want %b", modes[m], inv, {frame_valid, par_error, stop_error}, {1'b1, inv[0], 1'b0});
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_counter_saturate;
`ifdef UART_RX_ERR_CNT_EN
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if (par_err_cnt !== 2'd0) begin
      bad++;
      $display("FAIL cnt_clr: got %0d want %0d", par_err_cnt, 0);
    end
    for (int k = 1; k <= 5; k++) begin
      frame8(8'hA5, 1'b1, PAR_EVEN, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      total++;
      if (par_err_cnt !== ((k > 3) ? 2'd3 : 2'(k))) begin
        bad++;
        $display("FAIL cnt_sat_%0d: got %0d want %0d", k, par_err_cnt, (k > 3) ? 3 : k);
      end
    end
    frame8(8'hA5, 1'b1, PAR_EVEN, 1'b1, 1'b0, 1'b1, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++;
    if ({par_err_cnt, stop_err_cnt} !== 4'h0) begin
      bad++;
      $display("FAIL cnt_clr_wins: got %h want %h", {par_err_cnt, stop_err_cnt}, 4'h0);
    end
`endif
  endtask

  task automatic test_no_parity_two_stop;
    logic [6:0] d = 7'h55;
    par_en       = 1'b0;
    stop2        = 1'b1;
    frame_start7 = 1'b1;
    @(negedge clk);
    frame_start7 = 1'b0;
    par_en       = 1'b1;
    stop2        = 1'b0;
    for (int i = 0; i < 7; i++) strobe7(d[i]);
    strobe7(1'b1);
    total++;
    if ({frame_valid7, busy7} !== 2'b01) begin
      bad++;
      $display("FAIL w7_after8: got %b want %b", {frame_valid7, busy7}, 2'b01);
    end
    strobe7(1'b0);
    total++;
    if ({p_data7, frame_valid7, par_error7, stop_error7} !== {7'h55, 3'b101}) begin
      bad++;
      $display("FAIL w7_done: got %h want %h", {p_data7, frame_valid7, par_error7, stop_error7}, {7'h55, 3'b101});
    end
    @(negedge clk);
`ifdef UART_RX_ERR_CNT_EN
    total++;
    if ({stop_err_cnt7, par_err_cnt7} !== {8'd1, 8'd0}) begin
      bad++;
      $display("FAIL w7_cnt: got %h want %h", {stop_err_cnt7, par_err_cnt7}, {8'd1, 8'd0});
    end
`endif
  endtask

  task automatic test_reset_mid_frame;
    int fv_seen = 0;
    start8(1'b1, PAR_EVEN, 1'b0);
    for (int i = 0; i < 4; i++) strobe8(1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({p_data, frame_valid, par_error, stop_error, busy} !== 12'h000) begin
      bad++;
      $display("FAIL mid_reset: got %h want %h", {p_data, frame_valid, par_error, stop_error, busy}, 12'h000);
    end
`ifdef UART_RX_ERR_CNT_EN
    total++;
    if ({par_err_cnt, stop_err_cnt} !== 4'h0) begin
      bad++;
      $display("FAIL mid_reset_cnt: got %h want %h", {par_err_cnt, stop_err_cnt}, 4'h0);
    end
`endif
    for (int i = 0; i < 6; i++) begin
      strobe8(1'b1);
      if (frame_valid) fv_seen++;
    end
    total++;
    if ({fv_seen, busy} !== {32'd0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset_nofv: got fv=%0d busy=%b want fv=0 busy=0", fv_seen, busy);
    end
  endtask

  task automatic test_ignore_start;
    start8(1'b1, PAR_EVEN, 1'b0);
    for (int i = 0; i < 8; i++) begin
      frame_start = (i == 3);
      strobe8(1'b1);
    end
    frame_start = 1'b1;
    strobe8(1'b0);
    frame_start = 1'b0;
    strobe8(1'b1);
    total++;
    if ({p_data, frame_valid, par_error, stop_error} !== {8'hFF, 3'b100}) begin
      bad++;
      $display("FAIL ignore_start_ff: got %h want %h", {p_data, frame_valid, par_error, stop_error}, {8'hFF, 3'b100});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] d = 8'h0E;
    frame8(8'h81, 1'b1, PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if ({p_data, frame_valid, par_error} !== {8'h81, 2'b10}) begin
      bad++;
      $display("FAIL b2b_first: got %h want %h", {p_data, frame_valid, par_error}, {8'h81, 2'b10});
    end
    @(negedge clk);
    total++;
    if ({frame_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_idle: got %b want %b", {frame_valid, busy}, 2'b00);
    end
    par_en      = 1'b1;
    par_mode    = PAR_EVEN;
    stop2       = 1'b0;
    sampled_bit = 1'b1;
    frame_start = 1'b1;
    bit_valid   = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    for (int i = 0; i < 8; i++) strobe8(d[i]);
    strobe8(1'b1);
    strobe8(1'b1);
    total++;
    if ({p_data, frame_valid, par_error, stop_error} !== {8'h0E, 3'b100}) begin
      bad++;
      $display("FAIL b2b_second: got %h want %h", {p_data, frame_valid, par_error, stop_error}, {8'h0E, 3'b100});
    end
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    frame_start  = 1'b0;
    bit_valid    = 1'b0;
    sampled_bit  = 1'b1;
    par_en       = 1'b0;
    par_mode     = PAR_EVEN;
    stop2        = 1'b0;
    err_clr      = 1'b0;
    frame_start7 = 1'b0;
    bit_valid7   = 1'b0;
    @(negedge clk);
    test_reset();
    test_even_clean();
    test_parity_error();
    test_modes();
    test_counter_saturate();
    test_no_parity_two_stop();
    test_reset_mid_frame();
    test_ignore_start();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
